// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/execute sequencer with ALU and data-memory handshakes
module cpu_sequencer #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    output logic                instr_req,
    output logic [PC_WIDTH-1:0] instr_addr,
    input  logic [31:0]         instr_rdata,
    input  logic                instr_valid,
    output logic                alu_start,
    output logic [2:0]          alu_op,
    output logic [7:0]          alu_a,
    output logic [7:0]          alu_b,
    input  logic [7:0]          alu_result,
    input  logic                alu_done,
    output logic                mem_we,
    output logic [7:0]          mem_addr,
    output logic [7:0]          mem_wdata,
    output logic [PC_WIDTH-1:0] pc,
    output logic                zero_flag,
    output logic                halted,
    output logic                illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WAIT_ALU,
        S_WRITE,
        S_HALT
    } state_t;

    localparam logic [2:0] GRP_CTRL = 3'b000;
    localparam logic [2:0] GRP_ALU  = 3'b001;
    localparam logic [2:0] CMD_JMP  = 3'b001;
    localparam logic [2:0] CMD_JZ   = 3'b010;
    localparam logic [2:0] CMD_HALT = 3'b011;
    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_t              state, state_d;
    logic [31:0]         ir, ir_d;
    logic [PC_WIDTH-1:0] pc_d;
    logic                zero_flag_d, illegal_d;
    logic [7:0]          result, result_d;

    logic [2:0] ir_group, ir_cmd;
    logic [7:0] ir_arg1, ir_arg2, ir_address;
    logic       unused_ir_bits;

    assign ir_group       = ir[31:29];
    assign ir_cmd         = ir[28:26];
    assign ir_arg1        = ir[24:17];
    assign ir_arg2        = ir[15:8];
    assign ir_address     = ir[7:0];
    assign unused_ir_bits = ^{ir[25], ir[16]};

    assign instr_addr = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            ir        <= '0;
            zero_flag <= 1'b0;
            illegal   <= 1'b0;
            result    <= '0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            ir        <= ir_d;
            zero_flag <= zero_flag_d;
            illegal   <= illegal_d;
            result    <= result_d;
        end
    end

    always_comb begin
        state_d     = state;
        pc_d        = pc;
        ir_d        = ir;
        zero_flag_d = zero_flag;
        illegal_d   = illegal;
        result_d    = result;
        instr_req   = 1'b0;
        alu_start   = 1'b0;
        alu_op      = '0;
        alu_a       = '0;
        alu_b       = '0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        halted      = 1'b0;

        case (state)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                instr_req = 1'b1;
                if (instr_valid) begin
                    ir_d    = instr_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (ir_group)
                    GRP_CTRL: begin
                        case (ir_cmd)
                            CMD_JMP:  pc_d = PC_WIDTH'(ir_address);
                            CMD_JZ:   pc_d = zero_flag ? PC_WIDTH'(ir_address) : pc + PC_ONE;
                            CMD_HALT: pc_d = pc;
                            default:  pc_d = pc + PC_ONE;
                        endcase
                        if (ir_cmd == CMD_HALT) state_d = S_HALT;
                        else                    state_d = run ? S_FETCH : S_IDLE;
                    end
                    GRP_ALU: begin
                        alu_start = 1'b1;
                        alu_op    = ir_cmd;
                        alu_a     = ir_arg1;
                        alu_b     = ir_arg2;
                        state_d   = S_WAIT_ALU;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_WAIT_ALU: begin
                alu_op = ir_cmd;
                alu_a  = ir_arg1;
                alu_b  = ir_arg2;
                if (alu_done) begin
                    result_d    = alu_result;
                    zero_flag_d = (alu_result == 8'h00);
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                alu_op    = ir_cmd;
                alu_a     = ir_arg1;
                alu_b     = ir_arg2;
                mem_we    = 1'b1;
                mem_addr  = ir_address;
                mem_wdata = result;
                pc_d      = pc + PC_ONE;
                state_d   = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer against an instruction-level model
module tb_cpu_sequencer;

    logic        clk;
    logic        reset;
    logic        run;
    logic        instr_req;
    logic [7:0]  instr_addr;
    logic [31:0] instr_rdata;
    logic        instr_valid;
    logic        alu_start;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a, alu_b;
    logic [7:0]  alu_result;
    logic        alu_done;
    logic        mem_we;
    logic [7:0]  mem_addr, mem_wdata;
    logic [7:0]  pc;
    logic        zero_flag, halted, illegal;

    cpu_sequencer #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset), .run(run),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_rdata(instr_rdata), .instr_valid(instr_valid),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_done(alu_done),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .pc(pc), .zero_flag(zero_flag), .halted(halted), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model state: one step per instruction, no notion of cycles.
    logic [7:0]  m_pc;
    logic        m_zf, m_halt, m_ill;
    logic [8:0]  fetch_q[$];
    logic [18:0] alu_q[$];
    logic [15:0] mem_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] mk(input logic [2:0] g, input logic [2:0] c,
                                       input logic [7:0] a1, input logic [7:0] a2,
                                       input logic [7:0] ad);
        logic [1:0] junk;
        junk = 2'($urandom);
        return {g, c, junk[1], a1, junk[0], a2, ad};
    endfunction

    task automatic model_reset();
        m_pc = 8'h00; m_zf = 1'b0; m_halt = 1'b0; m_ill = 1'b0;
        fetch_q.delete(); alu_q.delete(); mem_q.delete();
    endtask

    task automatic model_exec(input logic [31:0] ins, input logic [7:0] res);
        logic [2:0] g, c;
        logic [7:0] ad;
        g = ins[31:29]; c = ins[28:26]; ad = ins[7:0];
        fetch_q.push_back({m_pc, m_zf});
        if (g == 3'd0) begin
            if (c == 3'd1)      m_pc = ad;
            else if (c == 3'd2) m_pc = m_zf ? ad : m_pc + 8'd1;
            else if (c == 3'd3) m_halt = 1'b1;
            else                m_pc = m_pc + 8'd1;
        end else if (g == 3'd1) begin
            alu_q.push_back({c, ins[24:17], ins[15:8]});
            mem_q.push_back({ad, res});
            m_zf = (res == 8'h00);
            m_pc = m_pc + 8'd1;
        end else begin
            m_halt = 1'b1;
            m_ill  = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic fetch_phase(input logic [31:0] ins, input logic [7:0] res,
                               input int fw, output bit ok);
        int n;
        n = 0;
        while (!instr_req && n < 50) begin tick(); n++; end
        check("fetch_request_seen", 32'(instr_req), 32'd1);
        ok = instr_req;
        if (!ok) return;
        model_exec(ins, res);
        repeat (fw) tick();
        instr_valid = 1'b1; instr_rdata = ins;
        tick();
        instr_valid = 1'b0; instr_rdata = $urandom;
    endtask

    task automatic wait_alu_start(output bit ok);
        int n;
        n = 0;
        while (!alu_start && n < 10) begin tick(); n++; end
        check("alu_start_seen", 32'(alu_start), 32'd1);
        ok = alu_start;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [7:0] res, input int fw,
                         input int aw, input bit early, input bit drop);
        bit ok;
        fetch_phase(ins, res, fw, ok);
        if (!ok || ins[31:29] != 3'b001) return;
        wait_alu_start(ok);
        if (!ok) return;
        // a done strobe overlapping alu_start must be ignored
        if (early) begin alu_done = 1'b1; alu_result = ~res; end
        tick();
        alu_done = 1'b0;
        if (drop) run = 1'b0;
        repeat (aw) tick();
        alu_done = 1'b1; alu_result = res;
        tick();
        alu_done = 1'b0; alu_result = 8'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Scoreboard monitor: pops an expectation for every observed DUT transaction.
    initial begin
        logic [8:0]  fe;
        logic [18:0] ae;
        logic [15:0] me;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (instr_req && instr_valid) begin
                    check("fetch_expected", 32'(fetch_q.size() != 0), 32'd1);
                    if (fetch_q.size() != 0) begin
                        fe = fetch_q.pop_front();
                        check("instr_addr", 32'(instr_addr), 32'(fe[8:1]));
                        check("pc_at_fetch", 32'(pc), 32'(fe[8:1]));
                        check("zero_flag_at_fetch", 32'(zero_flag), 32'(fe[0]));
                    end
                end
                if (alu_start) begin
                    check("alu_start_expected", 32'(alu_q.size() != 0), 32'd1);
                    if (alu_q.size() != 0) begin
                        ae = alu_q.pop_front();
                        check("alu_op_a_b", 32'({alu_op, alu_a, alu_b}), 32'(ae));
                    end
                end
                if (mem_we) begin
                    check("mem_we_expected", 32'(mem_q.size() != 0), 32'd1);
                    if (mem_q.size() != 0) begin
                        me = mem_q.pop_front();
                        check("mem_addr_wdata", 32'({mem_addr, mem_wdata}), 32'(me));
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        reset = 1'b1; run = 1'b0; instr_valid = 1'b0; instr_rdata = '0;
        alu_done = 1'b0; alu_result = '0;
        model_reset();
        repeat (3) tick();
        check("reset_outputs",
              32'({instr_req, alu_start, mem_we, halted, illegal, zero_flag}), 32'd0);
        check("reset_pc", 32'(pc), 32'h00);
        check("reset_alu_mem_buses", {alu_op, alu_a, alu_b, mem_addr, mem_wdata[4:0]}, 32'd0);
        reset = 1'b0;
        tick(); tick();
        check("idle_no_req", 32'(instr_req), 32'd0);
        run = 1'b1;

        issue(mk(3'd0, 3'd0, 8'h00, 8'h00, 8'h00), 8'h00, 1, 0, 0, 0);
        issue(mk(3'd1, 3'd2, 8'h05, 8'h03, 8'h40), 8'h08, 0, 2, 1, 0);
        issue(mk(3'd1, 3'd1, 8'h07, 8'h07, 8'h41), 8'h00, 0, 1, 0, 0);
        issue(mk(3'd0, 3'd2, 8'h00, 8'h00, 8'h10), 8'h00, 0, 0, 0, 0);
        issue(mk(3'd1, 3'd0, 8'h01, 8'h02, 8'h42), 8'h33, 2, 0, 1, 0);
        issue(mk(3'd0, 3'd2, 8'h00, 8'h00, 8'h20), 8'h00, 0, 0, 0, 0);
        issue(mk(3'd0, 3'd1, 8'h00, 8'h00, 8'hFF), 8'h00, 0, 0, 0, 0);
        issue(mk(3'd0, 3'd0, 8'h00, 8'h00, 8'h00), 8'h00, 0, 0, 0, 0);
        issue(mk(3'd0, 3'd1, 8'h00, 8'h00, 8'h80), 8'h00, 0, 0, 0, 0);
        issue(mk(3'd0, 3'd5, 8'h00, 8'h00, 8'h00), 8'h00, 1, 0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            logic [2:0] g, c;
            logic [7:0] res;
            g = 3'($urandom_range(0, 1));
            c = 3'($urandom_range(0, 7));
            if (g == 3'd0 && c == 3'd3) c = 3'd0;
            res = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            issue(mk(g, c, 8'($urandom), 8'($urandom), 8'($urandom)), res,
                  $urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom), 0);
        end

        // run dropped while the ALU is busy: the write still lands, then idle
        issue(mk(3'd1, 3'd4, 8'h11, 8'h22, 8'h55), 8'h9A, 0, 2, 0, 1);
        repeat (4) tick();
        check("run_drop_idle", 32'(instr_req), 32'd0);
        check("run_drop_pc", 32'(pc), 32'(m_pc));
        run = 1'b1;

        // reset while waiting on the ALU: late alu_done must not produce a write
        issue(mk(3'd1, 3'd3, 8'h01, 8'h01, 8'h60), 8'h00, 0, 0, 0, 0);
        fetch_phase(mk(3'd1, 3'd6, 8'hAA, 8'hBB, 8'h61), 8'h77, 0, ok);
        if (ok) wait_alu_start(ok);
        tick();
        reset = 1'b1; run = 1'b0;
        model_reset();
        tick();
        reset = 1'b0; alu_done = 1'b1; alu_result = 8'h00;
        tick();
        alu_done = 1'b0;
        repeat (3) tick();
        check("abort_pc", 32'(pc), 32'h00);
        check("abort_zero_flag", 32'(zero_flag), 32'd0);
        check("abort_idle", 32'({instr_req, halted}), 32'd0);

        run = 1'b1;
        issue(mk(3'd0, 3'd1, 8'h00, 8'h00, 8'h3C), 8'h00, 0, 0, 0, 0);
        issue(mk(3'd0, 3'd3, 8'h00, 8'h00, 8'h00), 8'h00, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin run = ~run; tick(); end
        check("halt_halted", 32'(halted), 32'(m_halt));
        check("halt_no_req", 32'(instr_req), 32'd0);
        check("halt_pc", 32'(pc), 32'(m_pc));
        check("halt_not_illegal", 32'(illegal), 32'(m_ill));

        run = 1'b0;
        do_reset();
        check("post_reset_unhalted", 32'({halted, illegal}), 32'd0);
        run = 1'b1;
        issue(mk(3'd0, 3'd1, 8'h00, 8'h00, 8'h25), 8'h00, 0, 0, 0, 0);
        issue(mk(3'd5, 3'd2, 8'h12, 8'h34, 8'h56), 8'h00, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin run = ~run; tick(); end
        check("illegal_flag", 32'(illegal), 32'(m_ill));
        check("illegal_halted", 32'(halted), 32'(m_halt));
        check("illegal_pc", 32'(pc), 32'(m_pc));

        check("fetch_q_drained", 32'(fetch_q.size()), 32'd0);
        check("alu_q_drained", 32'(alu_q.size()), 32'd0);
        check("mem_q_drained", 32'(mem_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
